// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data-memory responder for the CORE data port.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-low reset
//   mem_read   read request  (CORE MemRead)
//   mem_write  write request (CORE MemWrite)
//   addr       byte address  (CORE alu_result)
//   wdata      write data    (CORE DataWM)
//   rdata      read data     (CORE dataR), zero unless a good read is completing
//   ready      access completes this cycle
//   err        bad access (misaligned, out of range, read+write conflict), valid with ready
//   rd_count   saturating count of completed good reads  (ACCESS_COUNT_EN only)
//   wr_count   saturating count of completed good writes (ACCESS_COUNT_EN only)
//
// Parameters: AW word-address width (DEPTH = 2**AW), WAIT_CYCLES wait states (0..15).
// Optional feature macro: ACCESS_COUNT_EN adds the rd_count/wr_count ports and counters.
module dmem_responder #(
    parameter int AW          = 5,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
`ifdef ACCESS_COUNT_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
`endif
);
    localparam int         DEPTH     = 2 ** AW;
    localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0] CNT_INIT  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic          req;
    logic          op_rd, op_wr;
    logic [31:0]   op_addr, op_wdata;
    logic [AW-1:0] idx;
    logic          bad;
    logic          commit_rd, commit_wr;
    logic [31:0]   mem [DEPTH];

    assign req = mem_read | mem_write;

    // The access being answered: live inputs when zero-wait, otherwise the
    // request captured on entry to BUSY (later input changes are ignored).
    assign op_rd    = ZERO_WAIT ? mem_read  : rd_q;
    assign op_wr    = ZERO_WAIT ? mem_write : wr_q;
    assign op_addr  = ZERO_WAIT ? addr      : addr_q;
    assign op_wdata = ZERO_WAIT ? wdata     : wdata_q;

    assign idx = op_addr[AW+1:2];
    assign bad = (op_addr[1:0] != 2'b00) | (op_addr[31:AW+2] != '0) | (op_rd & op_wr);

    // Gating with rst forces all outputs low and blocks RAM writes during reset.
    assign ready     = rst & (ZERO_WAIT ? req : (state_q == BUSY && cnt_q == 4'd0));
    assign err       = ready & bad;
    assign commit_rd = ready & op_rd & ~bad;
    assign commit_wr = ready & op_wr & ~bad;
    assign rdata     = commit_rd ? mem[idx] : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (!ZERO_WAIT) begin
            if (state_q == IDLE && req) begin
                state_d = BUSY;
                cnt_d   = CNT_INIT;
                rd_d    = mem_read;
                wr_d    = mem_write;
                addr_d  = addr;
                wdata_d = wdata;
            end else if (state_q == BUSY) begin
                state_d = (cnt_q == 4'd0) ? IDLE : BUSY;
                cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // RAM is deliberately not reset; reads are asynchronous so a same-cycle
    // read sees the old word and the new one appears after this edge.
    always_ff @(posedge clk) begin
        if (commit_wr) mem[idx] <= op_wdata;
    end

`ifdef ACCESS_COUNT_EN
    logic [15:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (commit_rd && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
            if (commit_wr && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`endif
endmodule
